// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: captures a WIDTH-bit word over valid/ready and shifts it out one bit per clock.
// Define SERIAL_PATTERN_TX_PARITY_EN to append an even-parity bit to every frame.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             msb_first,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        ST_PAR   = 2'd2,
`endif
        ST_GAP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic             msb;
    logic [CW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic             done_q;
    logic             capture;
    logic             frame_end;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic             par;
`endif

    assign capture = (state == ST_IDLE) && din_valid;

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    assign frame_end = (state == ST_PAR);
`else
    assign frame_end = (state == ST_SHIFT) && (bit_cnt == CW'(1));
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: begin
                if (din_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt == CW'(1)) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    state_d = ST_PAR;
`else
                    state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
`endif
                end
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            ST_PAR: begin
                state_d = (GAP > 0) ? ST_GAP : ST_IDLE;
            end
`endif
            ST_GAP: begin
                if (gap_cnt == GW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The captured word and bit order are frozen for the whole frame; din/msb_first are ignored after capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            msb     <= 1'b0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            done_q  <= 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            done_q <= frame_end;
            if (capture) begin
                shreg   <= din;
                msb     <= msb_first;
                bit_cnt <= CW'(WIDTH);
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                par     <= ^din;
`endif
            end else if (state == ST_SHIFT) begin
                shreg   <= msb ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                bit_cnt <= bit_cnt - CW'(1);
            end
            if ((state_d == ST_GAP) && (state != ST_GAP)) begin
                gap_cnt <= GW'(GAP);
            end else if (state == ST_GAP) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
        end
    end

    always_comb begin
        sout = 1'b0;
        case (state)
            ST_SHIFT: sout = msb ? shreg[WIDTH-1] : shreg[0];
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            ST_PAR:   sout = par;
`endif
            default:  sout = 1'b0;
        endcase
    end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    assign sout_valid = (state == ST_SHIFT) || (state == ST_PAR);
`else
    assign sout_valid = (state == ST_SHIFT);
`endif
    assign busy      = (state != ST_IDLE);
    assign din_ready = (state == ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: directed and random frames checked against a bit-order/parity reference model.
// Honours SERIAL_PATTERN_TX_PARITY_EN so the same bench covers both builds.
module tb_serial_pattern_tx;

    localparam int WIDTH = 8;
    localparam int GAP   = 1;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    localparam int FL = WIDTH + 1;
`else
    localparam int FL = WIDTH;
`endif

    logic             clock;
    logic             reset_n;
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             msb_first;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    int vectors;
    int miscompares;

    serial_pattern_tx #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .msb_first  (msb_first),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Frame bit idx of word w: data bits in the requested order, then even parity of the word.
    function automatic logic ref_bit(input logic [WIDTH-1:0] w, input logic m, input int idx);
        int pos;
        int ones;
        if (idx >= WIDTH) begin
            ones = 0;
            for (int j = 0; j < WIDTH; j++) ones += int'((w >> j) & 1);
            return logic'(ones % 2);
        end
        pos = m ? (WIDTH - 1 - idx) : idx;
        return logic'((w >> pos) & 1);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, "_sout"}, {31'd0, sout}, 32'd0);
        check_output({tag, "_sout_valid"}, {31'd0, sout_valid}, 32'd0);
        check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, "_done"}, {31'd0, done}, 32'd0);
        check_output({tag, "_din_ready"}, {31'd0, din_ready}, 32'd1);
    endtask

    // Sends one word and checks every cycle of the frame, the gap and the return to idle.
    task automatic send_frame(input logic [WIDTH-1:0] w, input logic m, input logic toggle,
                              output logic [FL-1:0] bits);
        bits = '0;
        din       = w;
        msb_first = m;
        din_valid = 1'b1;
        check_output("ready_before", {31'd0, din_ready}, 32'd1);
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            check_output("bit_valid", {31'd0, sout_valid}, 32'd1);
            check_output("bit_value", {31'd0, sout}, {31'd0, ref_bit(w, m, i)});
            check_output("bit_busy", {31'd0, busy}, 32'd1);
            check_output("bit_ready", {31'd0, din_ready}, 32'd0);
            check_output("bit_done", {31'd0, done}, 32'd0);
            bits[i] = sout;
            if (toggle) begin
                msb_first = ~msb_first;
                din       = WIDTH'($urandom);
            end
            tick();
        end
        for (int g = 0; g < GAP; g++) begin
            check_output("gap_valid", {31'd0, sout_valid}, 32'd0);
            check_output("gap_sout", {31'd0, sout}, 32'd0);
            check_output("gap_busy", {31'd0, busy}, 32'd1);
            check_output("gap_ready", {31'd0, din_ready}, 32'd0);
            check_output("gap_done", {31'd0, done}, {31'd0, (g == 0)});
            tick();
        end
        check_output("end_ready", {31'd0, din_ready}, 32'd1);
        check_output("end_busy", {31'd0, busy}, 32'd0);
        check_output("end_done", {31'd0, done}, {31'd0, (GAP == 0)});
    endtask

    initial begin
        logic [FL-1:0]    bits;
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] bw;
        logic             m;
        logic             t;
        int               k;
        int               hits;
        logic             exp_v;

        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        din         = '0;
        din_valid   = 1'b0;
        msb_first   = 1'b0;

        #1;
        check_idle_outputs("por");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_idle_outputs("after_release");

        send_frame(8'hB4, 1'b1, 1'b0, bits);
        send_frame(8'hB4, 1'b0, 1'b1, bits);
        send_frame(8'hB5, 1'b1, 1'b0, bits);

        // Back-to-back words with din_valid held high.
        din       = 8'hFF;
        msb_first = 1'b1;
        din_valid = 1'b1;
        tick();
        din = 8'h00;
        for (int c = 0; c < 2 * FL + GAP + 2; c++) begin
            if (c < FL + GAP + 1) begin
                bw = 8'hFF;
                k  = c;
            end else begin
                bw = 8'h00;
                k  = c - (FL + GAP + 1);
            end
            exp_v = (k < FL);
            check_output("b2b_valid", {31'd0, sout_valid}, {31'd0, exp_v});
            check_output("b2b_sout", {31'd0, sout}, {31'd0, exp_v ? ref_bit(bw, 1'b1, k) : 1'b0});
            check_output("b2b_done", {31'd0, done}, {31'd0, (k == FL)});
            tick();
            if (c == FL + GAP) din_valid = 1'b0;
        end
        repeat (GAP + 1) tick();
        check_output("b2b_idle_ready", {31'd0, din_ready}, 32'd1);

        // Reset asserted after three bits of a frame.
        din       = 8'hA5;
        msb_first = 1'b1;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output("abort_bit", {31'd0, sout}, {31'd0, ref_bit(8'hA5, 1'b1, i)});
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < FL; i++) begin
            check_output("abort_no_done", {31'd0, done}, 32'd0);
            tick();
        end

        // Frame after reset drives a 1010 sequence detector model.
        send_frame(8'h0A, 1'b1, 1'b0, bits);
        hits = 0;
        for (int i = 3; i < FL; i++) begin
            if (bits[i-3] && !bits[i-2] && bits[i-1] && !bits[i]) hits++;
        end
        check_output("detect_1010", 32'(hits), 32'd1);

        for (int r = 0; r < 6; r++) begin
            w = WIDTH'($urandom);
            m = logic'($urandom_range(0, 1));
            t = logic'($urandom_range(0, 1));
            send_frame(w, m, t, bits);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
